// File: rtl/pcoder_pkg.sv
// Shared types and limits for the priority-coder pipeline.
package pcoder_pkg;

   typedef enum logic {FIXED, ROUND_ROBIN} pcoder_mode_e;

   localparam int unsigned PCODER_MAX_N = 64;

endpackage

// File: rtl/pcoder_core.sv
// Combinational fixed-priority encoder: highest set bit wins, index 0 when empty.
module pcoder_core #(
   parameter  int unsigned N = 8,
   localparam int unsigned W = $clog2(N)
) (
   input  logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic         any
);

   always_comb begin
      idx = '0;
      any = |req;
      for (int unsigned i = 0; i < N; i++) begin
         if (req[i]) idx = W'(i);
      end
   end

endmodule

// File: rtl/pcoder_pipe.sv
// Registered priority coder with valid/ready handshake; fixed or round-robin grant.
module pcoder_pipe
   import pcoder_pkg::*;
#(
   parameter  int unsigned  N    = 8,
   parameter  pcoder_mode_e MODE = FIXED,
   localparam int unsigned  W    = $clog2(N)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] in,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] code,
   output logic         any,
   output logic         out_valid,
   input  logic         out_ready
);

   logic         accept;
   logic [N-1:0] enc_req;
   logic [W-1:0] enc_idx;
   logic         enc_any;
   logic [W-1:0] grant;

   always_comb begin
      in_ready = !out_valid || out_ready;
      accept   = in_valid && in_ready;
   end

   pcoder_core #(.N(N)) u_core (
      .req (enc_req),
      .idx (enc_idx),
      .any (enc_any)
   );

   generate
      if (MODE == ROUND_ROBIN) begin : g_rr
         logic [W-1:0] ptr;
         logic [W:0]   k;
         logic [W:0]   sum;

         // Rotate so that request ptr lands on the encoder's top bit, then undo
         // the rotation on the index; sums stay below 2N so one subtract suffices.
         always_comb begin
            enc_req = '0;
            k       = '0;
            for (int unsigned j = 0; j < N; j++) begin
               k = (W+1)'(j) + {1'b0, ptr} + (W+1)'(1);
               if (k >= (W+1)'(N)) k = k - (W+1)'(N);
               enc_req[j] = in[k[W-1:0]];
            end
            sum = {1'b0, enc_idx} + {1'b0, ptr} + (W+1)'(1);
            if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
            grant = sum[W-1:0];
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               ptr <= W'(N-1);
            end else if (accept && enc_any) begin
               ptr <= (grant == '0) ? W'(N-1) : grant - W'(1);
            end
         end
      end else begin : g_fixed
         always_comb begin
            enc_req = in;
            grant   = enc_idx;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         code      <= '0;
         any       <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         code      <= enc_any ? grant : '0;
         any       <= enc_any;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pcoder_pipe.sv
// Scoreboard bench: three instances (N=8 FIXED, N=8 ROUND_ROBIN, N=5 ROUND_ROBIN).
module tb_pcoder_pipe;
   import pcoder_pkg::*;

   logic       clk;
   logic       reset;
   logic [7:0] in_v      [3];
   logic       in_valid  [3];
   logic       in_ready  [3];
   logic [2:0] code_o    [3];
   logic       any_o     [3];
   logic       out_valid [3];
   logic       out_ready [3];

   int tests = 0;
   int fails = 0;
   int sb0[$];
   int sb1[$];
   int sb2[$];

   pcoder_pipe #(.N(8), .MODE(FIXED)) u_fix (
      .clk(clk), .reset(reset), .in(in_v[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .code(code_o[0]), .any(any_o[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]));

   pcoder_pipe #(.N(8), .MODE(ROUND_ROBIN)) u_rr8 (
      .clk(clk), .reset(reset), .in(in_v[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .code(code_o[1]), .any(any_o[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]));

   pcoder_pipe #(.N(5), .MODE(ROUND_ROBIN)) u_rr5 (
      .clk(clk), .reset(reset), .in(in_v[2][4:0]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .code(code_o[2]), .any(any_o[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int d, input int exp_code, input int exp_any);
      case (d)
         0: sb0.push_back(exp_any * 8 + exp_code);
         1: sb1.push_back(exp_any * 8 + exp_code);
         default: sb2.push_back(exp_any * 8 + exp_code);
      endcase
   endtask

   // Offer a vector until accepted, record the expectation, check latency-1 result.
   task automatic send(input int d, input logic [7:0] vec, input int exp_code, input int exp_any);
      in_v[d]     = vec;
      in_valid[d] = 1'b1;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (in_ready[d]) begin
            push(d, exp_code, exp_any);
            @(posedge clk);
            #1;
            in_valid[d] = 1'b0;
            check("latency_valid", 32'(out_valid[d]), 32'd1);
            check("latency_code", 32'(code_o[d]), 32'(exp_code));
            return;
         end
      end
      tests++;
      fails++;
      $display("FAIL accept_timeout: dut %0d never ready, required ready within 20 cycles", d);
      in_valid[d] = 1'b0;
   endtask

   // Monitor: compare every presented result against the queue head; pop on handshake.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (out_valid[d]) begin
            logic [31:0] act;
            int          exp_v;
            act   = {28'd0, any_o[d], code_o[d]};
            exp_v = -1;
            case (d)
               0: if (sb0.size() > 0) exp_v = sb0[0];
               1: if (sb1.size() > 0) exp_v = sb1[0];
               default: if (sb2.size() > 0) exp_v = sb2[0];
            endcase
            if (exp_v < 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_output: dut %0d presented %0d with nothing expected", d, act);
            end else begin
               check("sb_result", act, 32'(exp_v));
            end
            if (d == 2) check("n5_code_range", 32'(code_o[2] <= 3'd4), 32'd1);
            if (out_ready[d] && exp_v >= 0) begin
               case (d)
                  0: void'(sb0.pop_front());
                  1: void'(sb1.pop_front());
                  default: void'(sb2.pop_front());
               endcase
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      for (int d = 0; d < 3; d++) begin
         in_v[d]      = '0;
         in_valid[d]  = 1'b0;
         out_ready[d] = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         check("reset_out_valid", 32'(out_valid[d]), 32'd0);
         check("reset_code", 32'(code_o[d]), 32'd0);
         check("reset_any", 32'(any_o[d]), 32'd0);
         check("reset_in_ready", 32'(in_ready[d]), 32'd1);
      end
      reset = 1'b0;

      send(0, 8'b0010_0110, 5, 1);
      send(0, 8'h00, 0, 0);
      send(0, 8'h01, 0, 1);
      send(0, 8'h80, 7, 1);

      // Stall with a new vector offered, then release: drain and accept together.
      out_ready[0] = 1'b0;
      in_v[0]      = 8'h10;
      in_valid[0]  = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("bp_in_ready", 32'(in_ready[0]), 32'd0);
         check("bp_code_hold", 32'(code_o[0]), 32'd7);
      end
      @(posedge clk);
      #1;
      out_ready[0] = 1'b1;
      send(0, 8'h10, 4, 1);

      send(1, 8'hFF, 7, 1);
      send(1, 8'hFF, 6, 1);
      send(1, 8'hFF, 5, 1);
      send(1, 8'hFF, 4, 1);
      send(1, 8'b1000_0001, 0, 1);
      send(1, 8'b1000_0001, 7, 1);
      send(1, 8'h00, 0, 0);
      send(1, 8'hFF, 6, 1);

      for (int i = 0; i < 5; i++) send(2, 8'h1F, 4 - i, 1);
      send(2, 8'h1F, 4, 1);

      // Round-robin reset with a result pending.
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb0.delete();
      sb1.delete();
      sb2.delete();
      send(1, 8'hFF, 7, 1);
      send(1, 8'hFF, 6, 1);
      out_ready[1] = 1'b0;
      reset        = 1'b1;
      @(posedge clk);
      #1;
      check("rr_reset_drop_valid", 32'(out_valid[1]), 32'd0);
      check("rr_reset_drop_code", 32'(code_o[1]), 32'd0);
      sb1.delete();
      reset        = 1'b0;
      out_ready[1] = 1'b1;
      send(1, 8'hFF, 7, 1);

      repeat (3) @(posedge clk);
      #1;
      check("sb0_drained", 32'(sb0.size()), 32'd0);
      check("sb1_drained", 32'(sb1.size()), 32'd0);
      check("sb2_drained", 32'(sb2.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pcoder_pipe.md
PCODER_PIPE -- requirements
Module: pcoder_pipe

Interface
REQ-001 SHALL have parameter N, default 8, meaning number of request inputs (legal range 2..64, need not be a power of 2).
REQ-002 SHALL have parameter MODE, default pcoder_pkg::FIXED, meaning arbitration mode (FIXED or ROUND_ROBIN).
REQ-003 SHALL have derived localparam W = $clog2(N), meaning code width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in  input  N  request vector; bit i is request i.
REQ-007 SHALL have port in_valid  input  1  in is valid this cycle.
REQ-008 SHALL have port in_ready  output  1  block accepts in this cycle.
REQ-009 SHALL have port code  output  W  index of the granted request.
REQ-010 SHALL have port any  output  1  at least one request bit was set in the accepted vector.
REQ-011 SHALL have port out_valid  output  1  code/any hold a result.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result this cycle.

Function
REQ-013 SHALL accept in when in_valid && in_ready (the "accept" event).
REQ-014 SHALL drive in_ready = !out_valid || out_ready, combinationally; no combinational path from in or in_valid to any output.
REQ-015 SHALL present the result for an accepted vector on code/any with out_valid=1 exactly one cycle after accept (latency 1).
REQ-016 SHALL hold code, any and out_valid stable while out_valid=1 and out_ready=0.
REQ-017 SHALL clear out_valid after out_valid && out_ready unless a new accept occurs in the same cycle, in which case the new result is loaded (full throughput, one result per cycle).
REQ-018 In FIXED mode SHALL grant the highest-index set bit (bit N-1 highest priority).
REQ-019 In ROUND_ROBIN mode SHALL keep a pointer ptr (W bits, range 0..N-1) and search from bit ptr downward, wrapping from 0 to N-1, granting the first set bit.
REQ-020 On an accept with a nonzero vector in ROUND_ROBIN mode SHALL update ptr to g-1, or to N-1 when granted index g = 0.
REQ-021 SHALL leave ptr unchanged on an accept with an all-zero vector and on cycles without accept.
REQ-022 For an all-zero accepted vector SHALL output code=0, any=0, out_valid=1.
REQ-023 SHALL never output code >= N, including for non-power-of-2 N.
REQ-024 In FIXED mode, ptr SHALL be absent or ignored, and results SHALL depend only on the accepted vector.

Reset
REQ-025 While reset=1 at a clock edge SHALL set out_valid=0, code=0, any=0, ptr=N-1; in_ready then reads 1.
REQ-026 Reset SHALL take precedence over a simultaneous accept or drain; a result pending at reset SHALL be discarded.

Structure
REQ-027 Package pcoder_pkg SHALL hold typedef enum pcoder_mode_e {FIXED, ROUND_ROBIN} and the limit constant PCODER_MAX_N = 64.
REQ-028 SHALL instantiate one combinational sub-module pcoder_core (N-wide fixed-priority encoder returning index and any); ROUND_ROBIN mode SHALL use it on the input rotated by ptr, then un-rotate the index modulo N.
REQ-029 Output registers and ptr SHALL be the only state; everything else is combinational.

Verification (N=8 unless stated)
REQ-030 Reset held for 2 cycles -> out_valid=0, code=0, any=0, in_ready=1.
REQ-031 FIXED: accept in=8'b0010_0110 -> next cycle out_valid=1, code=5, any=1; accept in=8'h00 -> code=0, any=0.
REQ-032 Backpressure: out_valid=1, out_ready=0, in_valid=1 for 3 cycles -> in_ready=0 and code stable throughout; out_ready=1 -> drain and accept happen in the same cycle, new result next cycle.
REQ-033 ROUND_ROBIN: back-to-back accepts of 8'hFF -> codes 7,6,5,4; then 8'b1000_0001 -> code 0; then 8'b1000_0001 again -> code 7 (wrap-around).
REQ-034 ROUND_ROBIN reset mid-operation: after grants 7,6 with a result pending, assert reset -> pending result dropped; next accept of 8'hFF -> code 7.
REQ-035 N=5, ROUND_ROBIN: five accepts of 5'b11111 -> codes 4,3,2,1,0, then 4; code never exceeds 4.
